// File: rtl/brainhack_run_ctrl_pkg.sv
// Shared encodings and width constants for the brainhack run controller and its core.
package brainhack_run_ctrl_pkg;

  localparam int INSTR_W_C  = 3;
  localparam int PRG_AW_C   = 8;
  localparam int TAPE_AW_C  = 8;
  localparam int TAPE_DW_C  = 8;
  localparam int STACK_AW_C = 4;
  localparam int CYC_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_RUN      = 3'd2,
    ST_DUMP_RD  = 3'd3,
    ST_DUMP_OUT = 3'd4,
    ST_DONE     = 3'd5
  } run_state_e;

  function automatic logic is_active(input run_state_e s);
    return (s != ST_IDLE) && (s != ST_DONE);
  endfunction

endpackage

// File: rtl/brainhack_dump_port.sv
// Dump datapath: tape read address, sent-cell counter and the valid/ready holding register.
module brainhack_dump_port
  import brainhack_run_ctrl_pkg::*;
#(
  parameter int TAPE_AW = TAPE_AW_C,
  parameter int TAPE_DW = TAPE_DW_C,
  parameter int DUMP_N  = 16
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_rd,
  input  logic               i_out,
  input  logic [TAPE_DW-1:0] i_tape_data,
  input  logic               i_dump_ready,
  output logic [TAPE_AW-1:0] o_tape_addr,
  output logic               o_dump_valid,
  output logic [TAPE_DW-1:0] o_dump_data,
  output logic               o_xfer,
  output logic               o_last
);

  localparam int               CNT_W    = TAPE_AW + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DUMP_N - 1);

  logic [TAPE_AW-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic [TAPE_DW-1:0] data_q, data_d;

  assign o_xfer       = valid_q & i_dump_ready;
  assign o_last       = (cnt_q == CNT_LAST);
  assign o_tape_addr  = addr_q;
  assign o_dump_valid = valid_q;
  assign o_dump_data  = data_q;

  // The address is advanced as soon as a cell is captured, so the synchronous
  // tape already holds the next address when the FSM returns to DUMP_RD.
  always_comb begin
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    data_d  = data_q;
    if (i_rd) begin
      addr_d  = addr_q + TAPE_AW'(1);
      valid_d = 1'b1;
      data_d  = i_tape_data;
    end else if (i_out) begin
      if (o_xfer && o_last) begin
        addr_d  = '0;
        cnt_d   = '0;
        valid_d = 1'b0;
        data_d  = '0;
      end else if (o_xfer) begin
        cnt_d   = cnt_q + CNT_W'(1);
        valid_d = 1'b0;
      end else begin
        valid_d = valid_q;
      end
    end else begin
      addr_d  = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
      data_d  = '0;
    end
  end

  // Dump state registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      addr_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/brainhack_run_ctrl.sv
// Run controller: loads a program, runs the core under a cycle limit, then dumps the tape.
module brainhack_run_ctrl
  import brainhack_run_ctrl_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_C,
  parameter int PRG_AW  = PRG_AW_C,
  parameter int TAPE_AW = TAPE_AW_C,
  parameter int TAPE_DW = TAPE_DW_C,
  parameter int DUMP_N  = 16,
  parameter int MAX_CYC = 65535
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_load_valid,
  input  logic [INSTR_W-1:0] i_load_data,
  input  logic               i_load_last,
  output logic               o_load_ready,
  output logic               o_prgmem_we,
  output logic [PRG_AW-1:0]  o_prgmem_addr,
  output logic [INSTR_W-1:0] o_prgmem_data,
  output logic               o_core_rst,
  output logic               o_core_en,
  input  logic [PRG_AW-1:0]  i_core_pc,
  output logic [TAPE_AW-1:0] o_tape_addr,
  input  logic [TAPE_DW-1:0] i_tape_data,
  output logic               o_dump_valid,
  output logic [TAPE_DW-1:0] o_dump_data,
  input  logic               i_dump_ready,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_timeout
);

  // The top address is reserved, so loading stops one short of it.
  localparam logic [PRG_AW-1:0] LOAD_END = PRG_AW'((1 << PRG_AW) - 2);
  localparam logic [CYC_W-1:0]  CYC_LAST = CYC_W'(MAX_CYC - 1);

  run_state_e        state_q, state_d;
  logic [PRG_AW-1:0] load_addr_q, load_addr_d;
  logic [PRG_AW-1:0] prog_len_q, prog_len_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic              timeout_q, timeout_d;
  logic              load_ready_q, core_en_q, core_rst_q, busy_q, done_q;
  logic              load_fire_s, halt_s, limit_s;
  logic              dump_rd_s, dump_out_s, dump_xfer_s, dump_last_s;

  assign load_fire_s = load_ready_q & i_load_valid;
  assign halt_s      = (i_core_pc == prog_len_q);
  assign limit_s     = (cyc_q == CYC_LAST);
  assign dump_rd_s   = (state_q == ST_DUMP_RD);
  assign dump_out_s  = (state_q == ST_DUMP_OUT);

  assign o_load_ready  = load_ready_q;
  assign o_prgmem_we   = load_fire_s;
  assign o_prgmem_addr = load_addr_q;
  assign o_prgmem_data = load_fire_s ? i_load_data : '0;
  assign o_core_rst    = core_rst_q;
  assign o_core_en     = core_en_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_timeout     = timeout_q;

  // Next-state and counter logic.
  always_comb begin
    state_d     = state_q;
    load_addr_d = load_addr_q;
    prog_len_d  = prog_len_q;
    cyc_d       = cyc_q;
    timeout_d   = timeout_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          state_d     = ST_LOAD;
          load_addr_d = '0;
          cyc_d       = '0;
          timeout_d   = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if (load_fire_s) begin
          load_addr_d = load_addr_q + PRG_AW'(1);
          if (i_load_last || (load_addr_q == LOAD_END)) begin
            prog_len_d = load_addr_q + PRG_AW'(1);
            state_d    = ST_RUN;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_RUN: begin
        cyc_d = cyc_q + CYC_W'(1);
        // Halt has priority over the limit in the same cycle.
        if (halt_s) begin
          state_d = ST_DUMP_RD;
        end else if (limit_s) begin
          state_d   = ST_DUMP_RD;
          timeout_d = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DUMP_RD: begin
        state_d = ST_DUMP_OUT;
      end
      ST_DUMP_OUT: begin
        if (dump_xfer_s && dump_last_s) begin
          state_d = ST_DONE;
        end else if (dump_xfer_s) begin
          state_d = ST_DUMP_RD;
        end else begin
          state_d = ST_DUMP_OUT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered status outputs decoded from the next state.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      load_addr_q  <= '0;
      prog_len_q   <= '0;
      cyc_q        <= '0;
      timeout_q    <= 1'b0;
      load_ready_q <= 1'b0;
      core_en_q    <= 1'b0;
      core_rst_q   <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_addr_q  <= load_addr_d;
      prog_len_q   <= prog_len_d;
      cyc_q        <= cyc_d;
      timeout_q    <= timeout_d;
      load_ready_q <= (state_d == ST_LOAD);
      core_en_q    <= (state_d == ST_RUN);
      core_rst_q   <= (state_d != ST_RUN);
      busy_q       <= is_active(state_d);
      done_q       <= (state_d == ST_DONE);
    end
  end

  brainhack_dump_port #(
    .TAPE_AW (TAPE_AW),
    .TAPE_DW (TAPE_DW),
    .DUMP_N  (DUMP_N)
  ) u_dump_port (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_rd         (dump_rd_s),
    .i_out        (dump_out_s),
    .i_tape_data  (i_tape_data),
    .i_dump_ready (i_dump_ready),
    .o_tape_addr  (o_tape_addr),
    .o_dump_valid (o_dump_valid),
    .o_dump_data  (o_dump_data),
    .o_xfer       (dump_xfer_s),
    .o_last       (dump_last_s)
  );

endmodule

// File: tb/tb_brainhack_run_ctrl.sv
// Randomized self-checking bench for brainhack_run_ctrl against a run-level reference model.
module tb_brainhack_run_ctrl;

  localparam int MAXC   = 20;
  localparam int DUMPN  = 16;
  localparam int MAXLEN = 255;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_start = 1'b0;
  logic       i_load_valid = 1'b0;
  logic [2:0] i_load_data = 3'd0;
  logic       i_load_last = 1'b0;
  logic [7:0] i_core_pc = 8'd0;
  logic [7:0] i_tape_data = 8'd0;
  logic       i_dump_ready = 1'b0;
  logic       o_load_ready, o_prgmem_we, o_core_rst, o_core_en;
  logic [7:0] o_prgmem_addr, o_tape_addr, o_dump_data;
  logic [2:0] o_prgmem_data;
  logic       o_dump_valid, o_busy, o_done, o_timeout;

  logic [7:0] tape_mem [256];
  int n_vec = 0;
  int n_err = 0;
  int top_writes = 0;

  always #5 clk = ~clk;

  // Synchronous-read tape with one cycle of latency.
  always @(posedge clk) i_tape_data <= tape_mem[o_tape_addr];

  always @(posedge clk) if (o_prgmem_we && o_prgmem_addr == 8'hFF) top_writes++;

  brainhack_run_ctrl #(.MAX_CYC(MAXC), .DUMP_N(DUMPN)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_start(i_start),
    .i_load_valid(i_load_valid), .i_load_data(i_load_data), .i_load_last(i_load_last),
    .o_load_ready(o_load_ready), .o_prgmem_we(o_prgmem_we), .o_prgmem_addr(o_prgmem_addr),
    .o_prgmem_data(o_prgmem_data), .o_core_rst(o_core_rst), .o_core_en(o_core_en),
    .i_core_pc(i_core_pc), .o_tape_addr(o_tape_addr), .i_tape_data(i_tape_data),
    .o_dump_valid(o_dump_valid), .o_dump_data(o_dump_data), .i_dump_ready(i_dump_ready),
    .o_busy(o_busy), .o_done(o_done), .o_timeout(o_timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_core_rst"}, o_core_rst, 1);
    check_eq({tag, "_core_en"}, o_core_en, 0);
    check_eq({tag, "_load_ready"}, o_load_ready, 0);
    check_eq({tag, "_we"}, o_prgmem_we, 0);
    check_eq({tag, "_dump_valid"}, o_dump_valid, 0);
    check_eq({tag, "_busy"}, o_busy, 0);
    check_eq({tag, "_done"}, o_done, 0);
    check_eq({tag, "_timeout"}, o_timeout, 0);
    check_eq({tag, "_tape_addr"}, o_tape_addr, 0);
    check_eq({tag, "_dump_data"}, o_dump_data, 0);
  endtask

  // last_at < 0: no i_load_last; halt_at == 0: pc never reaches prog_len.
  // ready_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
  task automatic do_run(input int last_at, input int halt_at, input int ready_mode, input bit ramp);
    int k, c, idx, p, budget, exp_len, exp_run;
    bit v, r, exp_to, prev_stall;
    logic [2:0] d;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 256; i++) tape_mem[i] = ramp ? 8'(8'h10 + i) : 8'($urandom);
    exp_len = (last_at >= 0 && last_at < MAXLEN - 1) ? last_at + 1 : MAXLEN;
    exp_run = (halt_at > 0 && halt_at <= MAXC) ? halt_at : MAXC;
    exp_to  = !(halt_at > 0 && halt_at <= MAXC);

    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    check_eq("load_ready", o_load_ready, 1);
    check_eq("load_busy", o_busy, 1);
    check_eq("load_core_rst", o_core_rst, 1);
    check_eq("load_done_clr", o_done, 0);
    check_eq("load_to_clr", o_timeout, 0);

    k = 0; budget = 0;
    while (o_load_ready && budget < 2000) begin
      v = ($urandom_range(0, 3) != 0);
      d = 3'($urandom);
      i_load_valid = v; i_load_data = d;
      i_load_last = (k == last_at);
      i_start = 1'($urandom_range(0, 1));
      #1;
      check_eq("prg_we", o_prgmem_we, v);
      if (v) begin
        check_eq("prg_addr", o_prgmem_addr, k);
        check_eq("prg_data", o_prgmem_data, d);
        k++;
      end
      @(negedge clk); budget++;
    end
    i_load_valid = 1'b0; i_load_last = 1'b0;
    check_eq("load_beats", k, exp_len);
    check_eq("run_core_en", o_core_en, 1);
    check_eq("run_core_rst", o_core_rst, 0);

    c = 0;
    while (o_core_en && c < 200) begin
      c++;
      i_core_pc = (c == halt_at) ? 8'(exp_len) : 8'(exp_len + 1);
      i_start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    check_eq("run_cycles", c, exp_run);
    check_eq("run_timeout", o_timeout, exp_to);
    check_eq("dump_busy", o_busy, 1);

    idx = 0; p = 0; budget = 0; prev_stall = 1'b0;
    while (!o_done && budget < 500) begin
      if (prev_stall) check_eq("stall_valid", o_dump_valid, 1);
      if (o_dump_valid) check_eq("dump_data", o_dump_data, tape_mem[idx % 256]);
      case (ready_mode)
        0: r = 1'b1;
        1: r = pat[p % 4];
        default: r = 1'($urandom_range(0, 1));
      endcase
      p++;
      i_dump_ready = r;
      i_start = 1'($urandom_range(0, 1));
      prev_stall = o_dump_valid && !r;
      if (o_dump_valid && r) idx++;
      @(negedge clk); budget++;
    end
    i_start = 1'b0; i_dump_ready = 1'b0;
    check_eq("dump_beats", idx, DUMPN);
    check_eq("done", o_done, 1);
    check_eq("done_busy", o_busy, 0);
    check_eq("done_timeout", o_timeout, exp_to);
    check_eq("done_valid", o_dump_valid, 0);
    check_eq("done_core_rst", o_core_rst, 1);
    check_eq("done_core_en", o_core_en, 0);
  endtask

  // where: 0 mid-LOAD with a beat pending, 1 mid-RUN, 2 mid-DUMP stalled.
  task automatic abort_test(input int where);
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    for (int k = 0; k < ((where == 0) ? 2 : 3); k++) begin
      i_load_valid = 1'b1; i_load_data = 3'(k); i_load_last = (k == 2);
      @(negedge clk);
    end
    if (where == 0) begin
      i_load_last = 1'b0;
      #1 check_eq("pre_abort_we", o_prgmem_we, 1);
    end else begin
      i_load_valid = 1'b0; i_load_last = 1'b0;
      i_core_pc = (where == 1) ? 8'd9 : 8'd3;
      i_dump_ready = 1'b0;
      repeat ((where == 1) ? 3 : 4) @(negedge clk);
      if (where == 1) check_eq("pre_abort_en", o_core_en, 1);
      else check_eq("pre_abort_dv", o_dump_valid, 1);
    end
    #2 i_reset = 1'b1;
    #1 check_reset_outputs("abort_async");
    @(negedge clk);
    check_eq("abort_no_we", o_prgmem_we, 0);
    i_reset = 1'b0; i_load_valid = 1'b0; i_load_last = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    check_eq("reset_prg_addr", o_prgmem_addr, 0);
    i_reset = 1'b0;

    do_run(2, 3, 0, 1'b1);
    do_run(-1, 7, 2, 1'b0);
    do_run(4, 1, 1, 1'b0);
    do_run(0, 0, 2, 1'b0);
    do_run(9, MAXC, 0, 1'b0);
    do_run(5, MAXC + 1, 2, 1'b0);
    for (int w = 0; w < 3; w++) begin
      abort_test(w);
      do_run(2, 3, 0, 1'b1);
    end
    for (int n = 0; n < 6; n++) begin
      do_run(($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 30)),
             int'($urandom_range(0, MAXC + 4)), int'($urandom_range(0, 2)), 1'b0);
    end
    check_eq("top_addr_writes", top_writes, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
